// File: rtl/multi_key_debouncer_pkg.sv
// Shared types and sizing helpers for the multi-key debouncer.
package debouncer_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_fsm_e;

  // One counter serves both the stability filter and the long-press hold time.
  function automatic int cnt_width(input int stable, input int long_cycles);
    int m;
    m = (stable > long_cycles) ? stable : long_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/multi_key_debouncer_if.sv
// Key inputs and debounced level/strobe outputs of the multi-key debouncer.
interface multi_key_debouncer_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_i;
  logic [NUM_KEYS-1:0] key_state_o;
  logic [NUM_KEYS-1:0] key_pressed_stb_o;
  logic [NUM_KEYS-1:0] key_released_stb_o;
  logic [NUM_KEYS-1:0] key_long_stb_o;

  modport master (
    output key_i,
    input  key_state_o, key_pressed_stb_o, key_released_stb_o, key_long_stb_o
  );

  modport slave (
    input  key_i,
    output key_state_o, key_pressed_stb_o, key_released_stb_o, key_long_stb_o
  );
endinterface

// File: rtl/multi_key_debouncer_channel.sv
// One key channel: synchroniser, debounce FSM and shared filter/hold counter.
//
// state        | meaning
// RELEASED     | key idle, level 0
// PRESS_WAIT   | key seen pressed, counting agreeing samples
// PRESSED      | press accepted, level 1, counting hold time
// RELEASE_WAIT | key seen released, counting agreeing samples, level still 1
module debounce_channel
  import debouncer_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int STABLE_CYCLES     = 16,
  parameter int LONG_PRESS_CYCLES = 1000,
  parameter int KEY_ACTIVE_LOW    = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_raw,
  output logic key_state,
  output logic pressed_stb,
  output logic released_stb,
  output logic long_stb
);

  localparam int CW = cnt_width(STABLE_CYCLES, LONG_PRESS_CYCLES);
  localparam logic          IDLE_LVL  = (KEY_ACTIVE_LOW != 0);
  localparam logic          LONG_EN   = (LONG_PRESS_CYCLES != 0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] STABLE_M1 = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_TC   = CW'(LONG_PRESS_CYCLES);
  localparam logic [CW-1:0] LONG_M1   = CW'(LONG_EN ? LONG_PRESS_CYCLES - 1 : 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  key_fsm_e               state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   press_d, release_d, long_d;

  assign s = sync_q[SYNC_STAGES-1] ^ IDLE_LVL;

  // The sample that leaves a stable state counts as the first agreeing one,
  // so a one-cycle filter accepts straight from RELEASED/PRESSED.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      RELEASED: begin
        cnt_d = '0;
        if (s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = PRESSED;
            press_d = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_M1) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          if (STABLE_CYCLES == 1) begin
            state_d   = RELEASED;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end
        end else if (LONG_EN && (cnt_q != LONG_TC)) begin
          cnt_d  = cnt_q + CNT_ONE;
          long_d = (cnt_q == LONG_M1);
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_M1) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Synchroniser resets to the idle pin level so an active-low key does not
  // look pressed while the first real samples ripple through.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q       <= {SYNC_STAGES{IDLE_LVL}};
      state_q      <= RELEASED;
      cnt_q        <= '0;
      key_state    <= 1'b0;
      pressed_stb  <= 1'b0;
      released_stb <= 1'b0;
      long_stb     <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], key_raw};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_state    <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
      pressed_stb  <= press_d;
      released_stb <= release_d;
      long_stb     <= long_d;
    end
  end

endmodule

// File: rtl/multi_key_debouncer.sv
// Debounces NUM_KEYS independent key inputs into levels plus press, release
// and long-press strobes.
module multi_key_debouncer
  import debouncer_pkg::*;
#(
  parameter int NUM_KEYS          = 4,
  parameter int SYNC_STAGES       = 2,
  parameter int STABLE_CYCLES     = 16,
  parameter int LONG_PRESS_CYCLES = 1000,
  parameter int KEY_ACTIVE_LOW    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  multi_key_debouncer_if.slave  keys
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("multi_key_debouncer: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("multi_key_debouncer: STABLE_CYCLES must be >= 1");
  end
  if (LONG_PRESS_CYCLES != 0 && LONG_PRESS_CYCLES <= STABLE_CYCLES) begin : g_bad_long
    $error("multi_key_debouncer: LONG_PRESS_CYCLES must be 0 or exceed STABLE_CYCLES");
  end

  logic [NUM_KEYS-1:0] state_v;
  logic [NUM_KEYS-1:0] press_v;
  logic [NUM_KEYS-1:0] release_v;
  logic [NUM_KEYS-1:0] long_v;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES       (SYNC_STAGES),
      .STABLE_CYCLES     (STABLE_CYCLES),
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
      .KEY_ACTIVE_LOW    (KEY_ACTIVE_LOW)
    ) u_ch (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .key_raw      (keys.key_i[g]),
      .key_state    (state_v[g]),
      .pressed_stb  (press_v[g]),
      .released_stb (release_v[g]),
      .long_stb     (long_v[g])
    );
  end

  assign keys.key_state_o        = state_v;
  assign keys.key_pressed_stb_o  = press_v;
  assign keys.key_released_stb_o = release_v;
  assign keys.key_long_stb_o     = long_v;

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Directed bench for multi_key_debouncer: default instance plus an
// active-low, single-sample-filter instance, with a strobe scoreboard.
module tb_multi_key_debouncer;
  import debouncer_pkg::*;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  typedef struct packed {
    logic       dut;
    logic [1:0] kind;
    logic [3:0] mask;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];

  multi_key_debouncer_if #(.NUM_KEYS(4)) bus ();
  multi_key_debouncer_if #(.NUM_KEYS(4)) bus_al ();

  multi_key_debouncer u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .keys  (bus)
  );

  multi_key_debouncer #(
    .NUM_KEYS       (4),
    .STABLE_CYCLES  (1),
    .KEY_ACTIVE_LOW (1)
  ) u_dut_al (
    .clk_i (clk),
    .rst_i (rst),
    .keys  (bus_al)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [3:0] stb_vec(input int d, input int k);
    if (d == 0) return (k == K_PRESS) ? bus.key_pressed_stb_o :
                       (k == K_RELEASE) ? bus.key_released_stb_o : bus.key_long_stb_o;
    return (k == K_PRESS) ? bus_al.key_pressed_stb_o :
           (k == K_RELEASE) ? bus_al.key_released_stb_o : bus_al.key_long_stb_o;
  endfunction

  task automatic expect_ev(input logic d, input int k, input logic [3:0] m, input int c);
    ev_t e;
    e.dut  = d;
    e.kind = k[1:0];
    e.mask = m;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every strobe the DUTs produce must match the next expected event.
  always @(negedge clk) begin : mon
    ev_t        obs;
    ev_t        e;
    logic [3:0] v;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) begin
        v = stb_vec(d, k);
        if (v != 4'b0) begin
          obs.dut  = d[0];
          obs.kind = k[1:0];
          obs.mask = v;
          obs.cyc  = cyc;
          n_assert++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL unexpected_event observed dut=%0d kind=%0d mask=%b cyc=%0d expected none",
                   obs.dut, obs.kind, obs.mask, obs.cyc);
          end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
              n_fail++;
              $error("FAIL strobe_event observed dut=%0d kind=%0d mask=%b cyc=%0d expected dut=%0d kind=%0d mask=%b cyc=%0d",
                     obs.dut, obs.kind, obs.mask, obs.cyc, e.dut, e.kind, e.mask, e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    int t;
    bus.key_i    = 4'b0000;
    bus_al.key_i = 4'b1111;

    // Reset with inputs toggling: every output stays 0
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.key_i    = ~bus.key_i;
      bus_al.key_i = ~bus_al.key_i;
      chk("reset_outputs",
          {bus.key_state_o, bus.key_pressed_stb_o, bus.key_released_stb_o, bus.key_long_stb_o,
           bus_al.key_state_o, bus_al.key_pressed_stb_o, bus_al.key_released_stb_o, bus_al.key_long_stb_o},
          32'h0);
    end
    @(negedge clk);
    bus.key_i    = 4'b0000;
    bus_al.key_i = 4'b1111;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(30);
    chk("idle_after_reset", {bus.key_state_o, bus_al.key_state_o}, 32'h0);

    // Press bounce on key0, then settle high
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.key_i[0] = ~bus.key_i[0];
    end
    t = cyc;
    expect_ev(1'b0, K_PRESS, 4'b0001, t + 18);
    wait_cycles(17);
    chk("state_before_press_accept", bus.key_state_o, 4'b0000);
    wait_cycles(1);
    chk("state_after_press", bus.key_state_o, 4'b0001);
    wait_cycles(20);

    // Release bounce on key0, then settle low
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.key_i[0] = ~bus.key_i[0];
    end
    @(negedge clk);
    bus.key_i[0] = 1'b0;
    t = cyc;
    expect_ev(1'b0, K_RELEASE, 4'b0001, t + 18);
    wait_cycles(17);
    chk("state_before_release_accept", bus.key_state_o, 4'b0001);
    wait_cycles(1);
    chk("state_after_release", bus.key_state_o, 4'b0000);
    wait_cycles(10);

    // Long press on key2
    bus.key_i[2] = 1'b1;
    t = cyc;
    expect_ev(1'b0, K_PRESS, 4'b0100, t + 18);
    expect_ev(1'b0, K_LONG,  4'b0100, t + 1018);
    wait_cycles(1200);
    chk("state_during_long_hold", bus.key_state_o, 4'b0100);
    bus.key_i[2] = 1'b0;
    t = cyc;
    expect_ev(1'b0, K_RELEASE, 4'b0100, t + 18);
    wait_cycles(30);
    chk("state_after_long_release", bus.key_state_o, 4'b0000);

    // Keys 1 and 3 together
    bus.key_i[1] = 1'b1;
    bus.key_i[3] = 1'b1;
    t = cyc;
    expect_ev(1'b0, K_PRESS, 4'b1010, t + 18);
    wait_cycles(40);
    chk("state_simultaneous", bus.key_state_o, 4'b1010);
    bus.key_i[1] = 1'b0;
    bus.key_i[3] = 1'b0;
    t = cyc;
    expect_ev(1'b0, K_RELEASE, 4'b1010, t + 18);
    wait_cycles(30);
    chk("state_simultaneous_release", bus.key_state_o, 4'b0000);

    // Reset in the middle of the press filter on key0
    bus.key_i[0] = 1'b1;
    wait_cycles(8);
    chk("fsm_in_press_wait", 32'(u_dut.g_ch[0].u_ch.state_q), 32'(PRESS_WAIT));
    rst = 1'b1;
    bus.key_i[0] = 1'b0;
    wait_cycles(1);
    chk("fsm_reset_mid_filter", 32'(u_dut.g_ch[0].u_ch.state_q), 32'(RELEASED));
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(40);
    chk("state_after_mid_reset", bus.key_state_o, 4'b0000);

    // Active-low, one-sample filter instance
    bus_al.key_i[0] = 1'b0;
    t = cyc;
    expect_ev(1'b1, K_PRESS, 4'b0001, t + 3);
    wait_cycles(2);
    chk("al_state_before_press", bus_al.key_state_o, 4'b0000);
    wait_cycles(1);
    chk("al_state_after_press", bus_al.key_state_o, 4'b0001);
    wait_cycles(10);
    bus_al.key_i[0] = 1'b1;
    t = cyc;
    expect_ev(1'b1, K_RELEASE, 4'b0001, t + 3);
    wait_cycles(10);
    chk("al_state_after_release", bus_al.key_state_o, 4'b0000);

    wait_cycles(20);
    chk("missing_events", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
